mem_arbiter: RTL and testbench

- Responder end of the cache/memory interface: serves one instruction-fetch requester (read-only) and one data-cache requester (read/write) against a single-port RAM.
- Arbitrates between the two, holds each requester with a wait signal until its access completes, and returns load data on completion.
- Sits between the cache pair and the RAM model.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_timer.sv | 29 ++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Used by mem_arbiter and mem_arb_timer.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    localparam logic [31:0] ERRWORD_DEFAULT = 32'hBAD1BAD1;
    localparam int          TIMER_MIN_W     = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating access-wait counter with synchronous clear and an at-limit flag.
// The clear input has priority over counting.
module mem_arb_timer #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic at_limit
);
    import mem_arbiter_pkg::*;

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            count <= '0;
        end else if (en && (count != LIM)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch (read-only) and data cache (read/write)
// over one single-port RAM. Optional perf counters under `MEMARB_PERF_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          DSTREAK = 4,
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] ERRWORD = ERRWORD_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
`ifdef MEMARB_PERF_EN
    ,
    output logic [31:0] dcount,
    output logic [31:0] icount,
    output logic [31:0] stallcyc
`endif
);

    localparam int TW = ($clog2(TIMEOUT + 1) > TIMER_MIN_W) ? $clog2(TIMEOUT + 1) : TIMER_MIN_W;
    localparam int SW = $clog2(DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK);

    state_t          state, next_state;
    ramstate_t       rs;
    logic [SW-1:0]   streak;
    logic            dreq;
    logic            at_limit;
    logic            dcomp_ok, dcomp_err, icomp_ok, icomp_err;

    assign rs   = ramstate_t'(ramstate);
    assign dreq = dREN | dWEN;

    mem_arb_timer #(
        .W     (TW),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (state == IDLE),
        .en       (state != IDLE),
        .at_limit (at_limit)
    );

    always_comb begin
        next_state = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        dcomp_ok   = 1'b0;
        dcomp_err  = 1'b0;
        icomp_ok   = 1'b0;
        icomp_err  = 1'b0;

        case (state)
            IDLE: begin
                // Instruction wins only once data has used up its streak.
                if (dreq && iREN && (streak == STREAK_MAX)) next_state = IACC;
                else if (dreq)                              next_state = DACC;
                else if (iREN)                              next_state = IACC;
            end

            DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (dWEN) ramWEN = 1'b1;
                else      ramREN = dREN;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (rs == ACCESS) begin
                    dwait      = 1'b0;
                    dload      = ramload;
                    dcomp_ok   = 1'b1;
                    next_state = IDLE;
                end else if ((rs == ERROR) || at_limit) begin
                    dwait      = 1'b0;
                    dload      = ERRWORD;
                    dcomp_err  = 1'b1;
                    next_state = IDLE;
                end
            end

            IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (rs == ACCESS) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    icomp_ok   = 1'b1;
                    next_state = IDLE;
                end else if ((rs == ERROR) || at_limit) begin
                    iwait      = 1'b0;
                    iload      = ERRWORD;
                    icomp_err  = 1'b1;
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            streak <= '0;
            memerr <= 1'b0;
        end else begin
            state <= next_state;
            if (dcomp_ok && (streak != STREAK_MAX)) streak <= streak + 1'b1;
            if ((state == IACC) && (next_state != IACC)) streak <= '0;
            if (dcomp_err || icomp_err) memerr <= 1'b1;
        end
    end

`ifdef MEMARB_PERF_EN
    logic stall;
    assign stall = (iREN & iwait) | (dreq & dwait);

    always_ff @(posedge CLK) begin
        if (RST) begin
            dcount   <= '0;
            icount   <= '0;
            stallcyc <= '0;
        end else begin
            if (dcomp_ok) dcount   <= dcount + 1'b1;
            if (icomp_ok) icount   <= icount + 1'b1;
            if (stall)    stallcyc <= stallcyc + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: load values are queued when a
// request is issued and popped by a monitor when a wait output drops.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam logic [31:0] ERRW = 32'hBAD1BAD1;
    localparam logic [31:0] KEY  = 32'h5A5A0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload, ramload_drv;
    logic [1:0]  ramstate;
    logic        memerr;
    logic        use_model;
`ifdef MEMARB_PERF_EN
    logic [31:0] dcount, icount, stallcyc;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] iexp[$];
    logic [31:0] dexp[$];

    // Simple RAM model: read data derived from the address when enabled.
    assign ramload = use_model ? (ramaddr ^ KEY) : ramload_drv;

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .memerr   (memerr)
`ifdef MEMARB_PERF_EN
        ,
        .dcount   (dcount),
        .icount   (icount),
        .stallcyc (stallcyc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    // Completion monitor: mutual exclusion of grants and scoreboard pops.
    always @(negedge CLK) begin
        check("one_grant", {31'b0, iwait | dwait}, 32'd1);
        if (!iwait) begin
            if (iexp.size() == 0) check("i_unexpected_pulse", {31'b0, iwait}, 32'd1);
            else                  check("iload", iload, iexp.pop_front());
        end
        if (!dwait) begin
            if (dexp.size() == 0) check("d_unexpected_pulse", {31'b0, dwait}, 32'd1);
            else                  check("dload", dload, dexp.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_order;
        byte   got[10];
        int    g, n;
        bit    done;

        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        ramstate = FREE; ramload_drv = 0; use_model = 0;
        step(); step();
        RST = 1'b0;

        // Reset state
        sample();
        check("rst_iwait",    {31'b0, iwait},  32'd1);
        check("rst_dwait",    {31'b0, dwait},  32'd1);
        check("rst_ramREN",   {31'b0, ramREN}, 32'd0);
        check("rst_ramWEN",   {31'b0, ramWEN}, 32'd0);
        check("rst_ramaddr",  ramaddr,  32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_iload",    iload,    32'd0);
        check("rst_dload",    dload,    32'd0);
        check("rst_memerr",   {31'b0, memerr}, 32'd0);
        step();

        // Instruction read, ACCESS on the third cycle
        iREN = 1; iaddr = 32'h40; ramstate = BUSY;
        iexp.push_back(32'h1234);
        sample();
        check("i_idle_iwait",  {31'b0, iwait},  32'd1);
        check("i_idle_ramREN", {31'b0, ramREN}, 32'd0);
        step();
        sample();
        check("i_busy_iwait",  {31'b0, iwait},  32'd1);
        check("i_busy_ramREN", {31'b0, ramREN}, 32'd1);
        check("i_busy_ramWEN", {31'b0, ramWEN}, 32'd0);
        check("i_busy_ramaddr", ramaddr, 32'h40);
        step();
        ramstate = ACCESS; ramload_drv = 32'h1234;
        sample();
        check("i_done_iwait",  {31'b0, iwait},  32'd0);
        check("i_done_ramWEN", {31'b0, ramWEN}, 32'd0);
        step();
        iREN = 0; ramstate = FREE;
        sample();
        check("i_after_iwait", {31'b0, iwait}, 32'd1);
        step();

        // Data write, ACCESS immediately
        dWEN = 1; daddr = 32'h3100; dstore = 32'hCAFE; ramload_drv = 32'h5555;
        dexp.push_back(32'h5555);
        sample();
        check("w_idle_ramWEN", {31'b0, ramWEN}, 32'd0);
        step();
        ramstate = ACCESS;
        sample();
        check("w_ramWEN",   {31'b0, ramWEN}, 32'd1);
        check("w_ramREN",   {31'b0, ramREN}, 32'd0);
        check("w_ramaddr",  ramaddr,  32'h3100);
        check("w_ramstore", ramstore, 32'hCAFE);
        check("w_dwait",    {31'b0, dwait}, 32'd0);
        step();
        dWEN = 0; ramstate = FREE;
        sample();
        check("w_next_ramWEN", {31'b0, ramWEN}, 32'd0);
        check("w_next_dwait",  {31'b0, dwait},  32'd1);
        step();

        // Continuous contention: DSTREAK data grants then one instruction grant
        pulse_reset();
        use_model = 1;
        iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h100; ramstate = ACCESS;
        for (int i = 0; i < 8; i++) dexp.push_back(32'h100 ^ KEY);
        for (int i = 0; i < 2; i++) iexp.push_back(32'h200 ^ KEY);
        exp_order = "DDDDIDDDDI";
        g = 0;
        for (int c = 0; c < 40 && g < 10; c++) begin
            sample();
            if (!dwait)      begin got[g] = "D"; g++; end
            else if (!iwait) begin got[g] = "I"; g++; end
            step();
        end
        check("grant_count", 32'(g), 32'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("grant%0d", i), 32'(got[i]), 32'(exp_order[i]));
        iREN = 0; dREN = 0; ramstate = FREE; use_model = 0;
        step();

        // Data read with RAM stuck BUSY -> timeout
        dREN = 1; daddr = 32'h44; ramstate = BUSY;
        dexp.push_back(ERRW);
        n = 0; done = 0;
        for (int c = 0; c < 400; c++) begin
            sample();
            if (!dwait) begin done = 1; break; end
            n++;
            step();
        end
        check("to_done",   {31'b0, done}, 32'd1);
        check("to_cycles", 32'(n), 32'd256);
        check("to_dload",  dload, ERRW);
        step();
        dREN = 0; ramstate = FREE;
        sample();
        check("to_memerr", {31'b0, memerr}, 32'd1);
        step(); step(); step();
        sample();
        check("to_memerr_sticky", {31'b0, memerr}, 32'd1);
        step();

        // Reset during a BUSY data access
        dREN = 1; daddr = 32'h60; ramstate = BUSY;
        sample();
        step();
        sample();
        check("rm_dacc_ramREN", {31'b0, ramREN}, 32'd1);
        step();
        RST = 1;
        sample();
        step();
        sample();
        check("rm_ramREN", {31'b0, ramREN}, 32'd0);
        check("rm_dwait",  {31'b0, dwait},  32'd1);
        check("rm_memerr", {31'b0, memerr}, 32'd0);
        step();
        RST = 0; dREN = 0; ramstate = FREE;
        sample();
        check("rm_after_dwait", {31'b0, dwait}, 32'd1);
        step();

        // Instruction read answered with ERROR
        iREN = 1; iaddr = 32'h80; ramstate = ERROR;
        iexp.push_back(ERRW);
        sample();
        step();
        sample();
        check("ie_iwait", {31'b0, iwait}, 32'd0);
        check("ie_iload", iload, ERRW);
        step();
        iREN = 0; ramstate = FREE;
        sample();
        check("ie_memerr", {31'b0, memerr}, 32'd1);
        step();
        pulse_reset();

        // dREN and dWEN together: write wins
        use_model = 1;
        dREN = 1; dWEN = 1; daddr = 32'h8; dstore = 32'h99; ramstate = ACCESS;
        dexp.push_back(32'h8 ^ KEY);
        sample();
        step();
        sample();
        check("rw_ramWEN",  {31'b0, ramWEN}, 32'd1);
        check("rw_ramREN",  {31'b0, ramREN}, 32'd0);
        check("rw_ramaddr", ramaddr, 32'h8);
        check("rw_dwait",   {31'b0, dwait}, 32'd0);
        step();
        dREN = 0; dWEN = 0; ramstate = FREE; use_model = 0;
        sample();
`ifdef MEMARB_PERF_EN
        check("perf_dcount",   dcount,   32'd1);
        check("perf_icount",   icount,   32'd0);
        check("perf_stallcyc", stallcyc, 32'd1);
`endif
        step();

        sample();
        check("iq_empty", 32'(iexp.size()), 32'd0);
        check("dq_empty", 32'(dexp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
